// File: rtl/alu_arbiter.sv
// Two-channel arbiter in front of one shared combinational ALU. Only one operation is in flight.
// Each operation runs IDLE -> EXEC -> RESP, or RESP -> EXEC when the next one is back-to-back.
module alu_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sign,
    input  logic [5:0]  req0_fun,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sign,
    input  logic [5:0]  req1_fun,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_sign,
    output logic [5:0]  alu_fun,
    input  logic [31:0] alu_z,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_z,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e      state_q;
    logic        last_q;
    logic        id_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sign_q;
    logic [5:0]  fun_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_z_q;

    logic        any_valid;
    logic        grant;
    logic        slot_open;
    logic        accept;

    // grant is only meaningful when any_valid is set
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            grant = req1_valid;
        end
        slot_open = !reset &&
                    ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
        accept     = slot_open && any_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            fun_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_z_q     <= '0;
        end else begin
            if (accept) begin
                id_q   <= grant;
                last_q <= grant;
                a_q    <= grant ? req1_a    : req0_a;
                b_q    <= grant ? req1_b    : req0_b;
                sign_q <= grant ? req1_sign : req0_sign;
                fun_q  <= grant ? req1_fun  : req0_fun;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_z_q     <= alu_z;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? StExec : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The ALU always sees the latched operands so its inputs never float
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sign  = sign_q;
    assign alu_fun   = fun_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;

endmodule
